icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: INDEX_BITS, default 4, log2 of the number of lines (16 lines).
REQ-002 Parameter: WORDS_PER_LINE, fixed 4; not overridable.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cpu_addr  input  16  fetch word address from the pipeline PC.
REQ-006 cpu_re  input  1  fetch request; lookup is performed only when high.
REQ-007 cpu_instr  output  16  instruction word; valid only while cpu_rdy=1.
REQ-008 cpu_rdy  output  1  hit indication; 0 means the pipeline stalls PC/IF-ID.
REQ-009 inv  input  1  single-cycle pulse that invalidates the whole cache.
REQ-010 mem_req  output  1  backing instruction memory read request.
REQ-011 mem_addr  output  16  backing memory word address; stable while mem_req=1.
REQ-012 mem_ack  input  1  backing memory data valid, any latency >=1 cycle.
REQ-013 mem_rdata  input  16  backing memory read data, sampled when mem_ack=1.

Function
REQ-014 Address split: offset=cpu_addr[1:0], index=cpu_addr[INDEX_BITS+1:2], tag=remaining upper bits.
REQ-015 Direct-mapped storage: per line one valid bit, one tag, 4 data words.
REQ-016 Lookup is combinational: cpu_rdy=cpu_re & (state==IDLE) & valid[index] & tag match, in the same cycle.
REQ-017 On hit, cpu_instr = stored word at index/offset, in the same cycle; otherwise cpu_instr=16'h0000.
REQ-018 FSM states: IDLE, FILL, COMMIT.
REQ-019 IDLE->FILL when cpu_re=1 and lookup misses; the miss tag/index are latched at that edge.
REQ-020 In FILL, mem_req=1 and mem_addr={latched tag, latched index, word counter}; the counter starts at 0.
REQ-021 On each mem_ack in FILL, mem_rdata is written to the word at the counter and the counter increments.
REQ-022 mem_req deasserts for exactly one cycle after each mem_ack; the next word is requested on the following cycle.
REQ-023 After the 4th mem_ack: FILL->COMMIT; in COMMIT the tag is written, valid is set, and the FSM returns to IDLE.
REQ-024 Miss-to-hit latency: a re-presented address hits in the cycle after COMMIT.
REQ-025 cpu_addr changes during FILL are ignored; the started fill always completes.
REQ-026 inv in IDLE clears all valid bits at the next edge; no cpu_rdy in that cycle.
REQ-027 inv during FILL or COMMIT clears all valid bits, and the line in flight is not marked valid.
REQ-028 mem_ack outside FILL is ignored.
REQ-029 Refill of an index overwrites that line unconditionally; no dirty state exists.

Reset
REQ-030 rst=1 at a clock edge: state=IDLE, all valid bits=0, counter=0, mem_req=0, and statistics counters=0.
REQ-031 rst during FILL abandons the fill; the partial line stays invalid and mem_req=0 from the next cycle.
REQ-032 Tag and data arrays are not reset.

Configuration
REQ-033 Macro ICACHE_STATS_EN defined: outputs hit_cnt[15:0] and miss_cnt[15:0] exist.
REQ-034 hit_cnt increments on each cycle with cpu_rdy=1.
REQ-035 miss_cnt increments on each IDLE->FILL transition.
REQ-036 Both statistics counters saturate at 16'hFFFF.
REQ-037 Macro not defined: these ports and counters are absent; all other behaviour is identical.

Verification
REQ-038 Cold miss: after reset, cpu_addr=16'h0040 with cpu_re=1 -> cpu_rdy=0; mem_addr runs 0040..0043; the hit arrives 1 cycle after COMMIT; memory returns ABCD and cpu_instr=16'hABCD at 0040.
REQ-039 Conflict: fill 16'h0040, then access 16'h0440 (same index, new tag) -> miss and refill; re-access 0040 -> miss again.
REQ-040 Variable latency: mem_ack delays of 1, 3, 7 and 2 cycles -> the line contents are correct and mem_addr stays stable while mem_req=1.
REQ-041 inv during the 3rd word of a fill -> the fill completes, and a re-access of the same address misses.
REQ-042 rst asserted mid-FILL -> mem_req=0 next cycle, state IDLE, and the next access misses.
REQ-043 ICACHE_STATS_EN: 1 miss and 3 hits -> hit_cnt=3, miss_cnt=1; forcing 70000 hits -> hit_cnt=16'hFFFF.

Source files
------------

// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and backing-memory signal bundle for icache
interface icache_if;
    logic [15:0] cpu_addr;
    logic        cpu_re;
    logic [15:0] cpu_instr;
    logic        cpu_rdy;
    logic        inv;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (
        output cpu_addr, cpu_re, inv, mem_ack, mem_rdata,
        input  cpu_instr, cpu_rdy, mem_req, mem_addr
    );

    modport slave (
        input  cpu_addr, cpu_re, inv, mem_ack, mem_rdata,
        output cpu_instr, cpu_rdy, mem_req, mem_addr
    );
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache, 4-word lines refilled one word per request
// Optional ICACHE_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module icache #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    icache_if.slave     bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);
    localparam int WORDS_PER_LINE = 4;
    localparam int LINES          = 1 << INDEX_BITS;
    localparam int TAG_BITS       = 14 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

    state_t state, state_nx;

    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [15:0]           data_mem [LINES*WORDS_PER_LINE];

    logic [1:0]            lk_off;
    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   fill_tag;
    logic [1:0]            word_cnt;
    logic                  ack_gap;
    logic                  inv_seen;
    logic                  tag_hit;
    logic                  hit;
    logic                  miss;
    logic                  ack_take;
    logic                  last_ack;

    assign lk_off  = bus.cpu_addr[1:0];
    assign lk_idx  = bus.cpu_addr[INDEX_BITS+1:2];
    assign lk_tag  = bus.cpu_addr[15:INDEX_BITS+2];
    assign tag_hit = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);

    // A same-cycle invalidate suppresses the hit so the pipeline never sees stale data.
    assign hit  = bus.cpu_re && (state == IDLE) && tag_hit && !bus.inv;
    assign miss = bus.cpu_re && (state == IDLE) && !tag_hit;

    assign bus.cpu_rdy   = hit;
    assign bus.cpu_instr = hit ? data_mem[{lk_idx, lk_off}] : 16'h0000;
    assign bus.mem_req   = (state == FILL) && !ack_gap;
    assign bus.mem_addr  = {fill_tag, fill_idx, word_cnt};

    assign ack_take = bus.mem_req && bus.mem_ack;
    assign last_ack = ack_take && (word_cnt == 2'd3);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (miss) state_nx = FILL;
            FILL:    if (last_ack) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            valid    <= '0;
            word_cnt <= 2'd0;
            ack_gap  <= 1'b0;
            inv_seen <= 1'b0;
        end else begin
            state   <= state_nx;
            ack_gap <= ack_take;
            if (miss) begin
                word_cnt <= 2'd0;
                inv_seen <= 1'b0;
            end
            if (ack_take) word_cnt <= word_cnt + 2'd1;
            // An invalidate seen anywhere in the refill keeps the in-flight line invalid.
            if (bus.inv) begin
                valid <= '0;
                if (state != IDLE) inv_seen <= 1'b1;
            end else if (state == COMMIT && !inv_seen) begin
                valid[fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (miss) begin
            fill_tag <= lk_tag;
            fill_idx <= lk_idx;
        end
        if (ack_take) data_mem[{fill_idx, word_cnt}] <= bus.mem_rdata;
        if (state == COMMIT) tag_mem[fill_idx] <= fill_tag;
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= 16'd0;
            miss_cnt <= 16'd0;
        end else begin
            if (hit && hit_cnt != 16'hFFFF)   hit_cnt  <= hit_cnt + 16'd1;
            if (miss && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache with a latency-programmable memory responder
module tb_icache;
    logic clk;
    logic rst;
`ifdef ICACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    icache_if ifc();

    icache #(.INDEX_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;
    int last_wait;
    logic [15:0] bmem [0:65535];
    int lat_q[$];
    logic [15:0] addr_log[$];

    // Reference model: per-line valid flag and tag, updated from observed outcomes.
    bit          v_m [16];
    logic [9:0]  t_m [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s wait bound expired", nm);
    endtask

    function automatic bit model_hit(input logic [15:0] a);
        return v_m[a[5:2]] && (t_m[a[5:2]] == a[15:6]);
    endfunction

    task automatic model_inv();
        for (int i = 0; i < 16; i++) v_m[i] = 1'b0;
    endtask

    task automatic model_fill(input logic [15:0] a);
        v_m[a[5:2]] = 1'b1;
        t_m[a[5:2]] = a[15:6];
    endtask

    // Memory responder: ack arrives L cycles after the request first appears.
    bit          pending;
    int          remaining;
    logic [15:0] req_addr;
    initial begin
        ifc.mem_ack = 1'b0;
        ifc.mem_rdata = 16'h0000;
        pending = 1'b0;
        remaining = 0;
        forever begin
            @(negedge clk);
            if (ifc.mem_ack) begin
                ifc.mem_ack = 1'b0;
                pending = 1'b0;
                chk("req_gap_after_ack", ifc.mem_req, 1'b0);
            end else if (!ifc.mem_req) begin
                pending = 1'b0;
            end else if (!pending) begin
                pending = 1'b1;
                req_addr = ifc.mem_addr;
                addr_log.push_back(req_addr);
                remaining = (lat_q.size() > 0) ? lat_q.pop_front() : int'($urandom_range(1, 4));
            end else begin
                chk("mem_addr_stable", ifc.mem_addr, req_addr);
                remaining--;
                if (remaining == 0) begin
                    ifc.mem_ack = 1'b1;
                    ifc.mem_rdata = bmem[req_addr];
                end
            end
        end
    end

    // exp_hit < 0 means take the expectation from the model.
    task automatic access(input logic [15:0] a, input int exp_hit, input string nm);
        int n;
        logic eh;
        eh = (exp_hit < 0) ? model_hit(a) : exp_hit[0];
        ifc.cpu_addr = a;
        ifc.cpu_re = 1'b1;
        @(negedge clk);
        chk({nm, "_first_rdy"}, ifc.cpu_rdy, eh);
        if (!ifc.cpu_rdy) chk({nm, "_stall_instr"}, ifc.cpu_instr, 16'h0000);
        n = 0;
        while (!ifc.cpu_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        if (ifc.cpu_rdy) begin
            chk({nm, "_instr"}, ifc.cpu_instr, bmem[a]);
            model_fill(a);
        end else begin
            bound_fail({nm, "_hit_timeout"});
        end
        @(posedge clk);
        #1;
        ifc.cpu_re = 1'b0;
    endtask

    typedef struct {
        logic [15:0] addr;
        int          exp_hit;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int n;
        tbl[0]  = '{16'h0041, 1};
        tbl[1]  = '{16'h0043, 1};
        tbl[2]  = '{16'h0440, 0};
        tbl[3]  = '{16'h0442, 1};
        tbl[4]  = '{16'h0040, 0};
        tbl[5]  = '{16'h0044, 0};
        tbl[6]  = '{16'h0042, 1};
        tbl[7]  = '{16'h0047, 1};
        tbl[8]  = '{16'hFFF0, 0};
        tbl[9]  = '{16'hFFF3, 1};
        tbl[10] = '{16'h0440, 0};
        tbl[11] = '{16'h0045, 1};

        for (int i = 0; i < 65536; i++) bmem[i] = 16'(i * 40503) ^ 16'h5A5A;
        bmem[16'h0040] = 16'hABCD;
        model_inv();

        ifc.cpu_addr = 16'h0000;
        ifc.cpu_re = 1'b0;
        ifc.inv = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", ifc.mem_req, 1'b0);
        chk("rst_cpu_rdy", ifc.cpu_rdy, 1'b0);
        chk("rst_cpu_instr", ifc.cpu_instr, 16'h0000);
`ifdef ICACHE_STATS_EN
        chk("rst_hit_cnt", hit_cnt, 16'd0);
        chk("rst_miss_cnt", miss_cnt, 16'd0);
`endif
        rst = 1'b0;

        // Cold miss, unit latency: hit lands 1 + 4*(1+2) cycles after the miss.
        lat_q = '{1, 1, 1, 1};
        addr_log.delete();
        access(16'h0040, 0, "cold");
        chk("cold_latency", last_wait, 13);
        chk("cold_req_count", addr_log.size(), 4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            chk("cold_mem_addr", addr_log[i], 16'h0040 + 16'(i));

        for (int i = 0; i < 12; i++) access(tbl[i].addr, tbl[i].exp_hit, $sformatf("tbl%0d", i));

        // Variable latency 1,3,7,2.
        lat_q = '{1, 3, 7, 2};
        addr_log.delete();
        access(16'h0080, 0, "varlat");
        chk("varlat_latency", last_wait, 1 + 13 + 8);
        chk("varlat_req_count", addr_log.size(), 4);
        for (int i = 1; i < 4; i++) access(16'h0080 + 16'(i), 1, $sformatf("varlat_w%0d", i));

        // Invalidate during the third word: fill finishes but the line stays invalid.
        lat_q = '{2, 2, 4, 2};
        addr_log.delete();
        ifc.cpu_addr = 16'h0100;
        ifc.cpu_re = 1'b1;
        @(posedge clk);
        #1;
        ifc.cpu_re = 1'b0;
        ifc.cpu_addr = 16'h0333;
        n = 0;
        while (!(ifc.mem_req && ifc.mem_addr == 16'h0102) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) bound_fail("inv_fill_third_word");
        ifc.inv = 1'b1;
        @(posedge clk);
        #1;
        ifc.inv = 1'b0;
        model_inv();
        repeat (30) @(posedge clk);
        #1;
        chk("inv_fill_req_count", addr_log.size(), 4);
        if (addr_log.size() == 4) chk("inv_fill_last_addr", addr_log[3], 16'h0103);
        chk("inv_fill_idle", ifc.mem_req, 1'b0);
        access(16'h0100, 0, "inv_fill_reaccess");

        // Invalidate in IDLE on a would-be hit.
        access(16'h0040, -1, "pre_inv_idle");
        ifc.cpu_addr = 16'h0040;
        ifc.cpu_re = 1'b1;
        ifc.inv = 1'b1;
        @(negedge clk);
        chk("inv_idle_rdy", ifc.cpu_rdy, 1'b0);
        @(posedge clk);
        #1;
        ifc.inv = 1'b0;
        ifc.cpu_re = 1'b0;
        model_inv();
        access(16'h0040, 0, "inv_idle_reaccess");

        // Reset in the middle of a fill.
        lat_q = '{6};
        ifc.cpu_addr = 16'h0200;
        ifc.cpu_re = 1'b1;
        @(posedge clk);
        #1;
        ifc.cpu_re = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fill_req_up", ifc.mem_req, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_fill_req_down", ifc.mem_req, 1'b0);
        lat_q.delete();
        model_inv();
        access(16'h0200, 0, "rst_fill_reaccess");
        access(16'h0041, 0, "rst_other_line");

        // Randomized accesses against the model.
        for (int i = 0; i < 80; i++) begin
            logic [15:0] a;
            a = (16'($urandom_range(0, 2)) << 6) | 16'($urandom_range(0, 63));
            access(a, -1, $sformatf("rnd%0d", i));
        end

`ifdef ICACHE_STATS_EN
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_inv();
        chk("stats_clr_hit", hit_cnt, 16'd0);
        chk("stats_clr_miss", miss_cnt, 16'd0);
        access(16'h0040, 0, "stats_miss");
        access(16'h0041, 1, "stats_hit1");
        access(16'h0042, 1, "stats_hit2");
        chk("stats_hit_cnt", hit_cnt, 16'd3);
        chk("stats_miss_cnt", miss_cnt, 16'd1);
        ifc.cpu_addr = 16'h0040;
        ifc.cpu_re = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        ifc.cpu_re = 1'b0;
        chk("stats_hit_sat", hit_cnt, 16'hFFFF);
        chk("stats_miss_hold", miss_cnt, 16'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
